stage_if: RTL and testbench
===========================

Name: stage_IF

Overview:
Instruction-fetch stage. It owns the PC register, issues one outstanding request at a time to instruction memory over a valid/ready request and valid response interface, and loads the IF/ID pipeline register that the decode stage consumes. It accepts the decode stage's redirect (pc_sel, pc_imm), its flush (IF_flush) and the hazard unit's stall. It kills in-flight fetches on a redirect.

Parameters:
PC_WIDTH, 32, width of PC and IMEM address
INST_WIDTH, 32, instruction width
REG_ADDR_WIDTH, 5, width of register-address fields extracted for decode
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
stall  in  1  hazard unit: hold IF/ID and PC
pc_sel  in  1  decode redirect request
pc_imm  in  PC_WIDTH  redirect target
IF_flush  in  1  decode: squash IF/ID contents
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  IMEM accepts request
imem_addr  out  PC_WIDTH  fetch address
imem_rsp_valid  in  1  response valid (single-cycle pulse, ≥1 cycle after accept)
imem_rsp_data  in  INST_WIDTH  fetched instruction
IF_ID_pc  out  PC_WIDTH  IF/ID PC
IF_ID_inst  out  INST_WIDTH  IF/ID instruction
IF_ID_rs1  out  REG_ADDR_WIDTH  IF_ID_inst[19:15]
IF_ID_rs2  out  REG_ADDR_WIDTH  IF_ID_inst[24:20]
IF_ID_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset: pc_q=RESET_PC, kill=0, state S_IDLE. Outputs: IF_ID_pc=0, IF_ID_inst=NOP_INST, rs1=0, rs2=0, IF_ID_valid=0, imem_req_valid=0.
- FSM states: S_IDLE, S_REQ, S_WAIT, S_HOLD.
- S_IDLE: go to S_REQ on the next cycle.
- S_REQ: imem_req_valid=1, imem_addr=pc_q (combinational from state and pc_q). On valid&&ready: req_pc<=pc_q, go to S_WAIT.
- Redirect in S_REQ before accept: pc_q<=pc_imm and imem_addr changes. IMEM samples only on the handshake cycle. If pc_sel and ready occur together, the accepted address is the old pc_q; set kill.
- S_WAIT: on rsp_valid:
  - kill=1 or pc_sel=1: discard the response, clear kill, go to S_REQ.
  - Otherwise, stall=0: load IF/ID with req_pc and rsp_data, valid=1; pc_q<=req_pc+4; go to S_REQ.
  - Otherwise, stall=1: capture into hold buffer, pc_q<=req_pc+4, go to S_HOLD.
  - pc_sel in S_WAIT without rsp_valid: pc_q<=pc_imm, kill<=1.
- S_HOLD: stall=0: move buffer into IF/ID (valid=1), go to S_REQ. pc_sel: discard buffer, pc_q<=pc_imm, go to S_REQ.
- IF/ID update priority, per cycle:
  1. IF_flush=1 loads NOP_INST, valid=0, pc=0. Flush wins over stall.
  2. Else stall=1 holds.
  3. Else a new instruction loads it.
  4. Else a bubble loads NOP_INST, valid=0.
- PC arithmetic is modulo 2^PC_WIDTH; 0xFFFF_FFFC+4 wraps to 0. pc_imm is used as given; no alignment check.
- Only one outstanding request. A new request is never issued in the cycle a response is consumed (S_WAIT goes to S_REQ, then req_valid). Fetch throughput is therefore at most one instruction per 2 cycles with 1-cycle memory latency.
- rsp_valid outside S_WAIT is ignored.
- Reset mid-operation returns all state to reset values immediately (async). A response arriving after reset release is ignored because the state is not S_WAIT.

Decomposition:
- Shared defines header risc_v_defines.vh gains RESET_PC, NOP_INST and the IF FSM state encodings (2-bit).
- Sub-module if_id_reg: the IF/ID register with flush/stall/load/bubble priority, reused by the pipeline top.

Test Plan:
1. Reset release, ready=1, 1-cycle latency, rsp_data=0x00500093 at PC 0 → IF_ID_pc=0, IF_ID_inst=0x00500093, rs1=0, rs2=5, valid=1; next imem_addr=4.
2. stall=1 held 3 cycles when the response for PC 8 arrives → IF/ID unchanged, no new req. After stall drops, IF/ID gets PC 8 and the next imem_addr is 0xC.
3. pc_sel=1, pc_imm=0x100 while in S_WAIT for PC 0x10 → that response is discarded, next imem_addr=0x100, no IF/ID entry for 0x10.
4. IF_flush=1 with stall=1 simultaneously → IF_ID_inst=0x00000013, valid=0.
5. imem_req_ready low for 4 cycles → imem_req_valid stays 1 with a stable address; pc_sel during the wait changes the address to pc_imm before accept.
6. reset asserted during S_WAIT, then rsp_valid pulses → outputs at reset values, response ignored, first post-reset fetch at RESET_PC.

Source files
------------

// File: rtl/stage_if_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch stage.
package stage_if_pkg;

  localparam int IF_PC_W   = 32;
  localparam int IF_INST_W = 32;
  localparam int IF_REG_W  = 5;

  localparam logic [IF_PC_W-1:0]   IF_RESET_PC = 32'h0000_0000;
  localparam logic [IF_INST_W-1:0] IF_NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } if_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Priority: flush, then stall (hold), then load, else bubble.
module if_id_reg #(
  parameter int                    PC_WIDTH   = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_i,
  input  logic                  stall_i,
  input  logic                  load_i,
  input  logic [PC_WIDTH-1:0]   pc_i,
  input  logic [INST_WIDTH-1:0] inst_i,
  output logic [PC_WIDTH-1:0]   pc_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic                  valid_o
);

  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  valid_q, valid_d;

  always_comb begin
    pc_d    = '0;
    inst_d  = NOP_INST;
    valid_d = 1'b0;
    if (flush_i) begin
      pc_d    = '0;
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (stall_i) begin
      pc_d    = pc_q;
      inst_d  = inst_q;
      valid_d = valid_q;
    end else if (load_i) begin
      pc_d    = pc_i;
      inst_d  = inst_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: PC, single-outstanding IMEM fetch FSM,
// redirect/kill handling and the IF/ID register.
module stage_if
  import stage_if_pkg::*;
#(
  parameter int                    PC_WIDTH       = IF_PC_W,
  parameter int                    INST_WIDTH     = IF_INST_W,
  parameter int                    REG_ADDR_WIDTH = IF_REG_W,
  parameter logic [PC_WIDTH-1:0]   RESET_PC       = IF_RESET_PC,
  parameter logic [INST_WIDTH-1:0] NOP_INST       = IF_NOP_INST
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      pc_sel,
  input  logic [PC_WIDTH-1:0]       pc_imm,
  input  logic                      IF_flush,
  output logic                      imem_req_valid,
  input  logic                      imem_req_ready,
  output logic [PC_WIDTH-1:0]       imem_addr,
  input  logic                      imem_rsp_valid,
  input  logic [INST_WIDTH-1:0]     imem_rsp_data,
  output logic [PC_WIDTH-1:0]       IF_ID_pc,
  output logic [INST_WIDTH-1:0]     IF_ID_inst,
  output logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
  output logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
  output logic                      IF_ID_valid
);

  if_state_e             state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   req_pc_q, req_pc_d;
  logic [PC_WIDTH-1:0]   hold_pc_q, hold_pc_d;
  logic [INST_WIDTH-1:0] hold_inst_q, hold_inst_d;
  logic                  kill_q, kill_d;

  logic                  ld;
  logic [PC_WIDTH-1:0]   ld_pc;
  logic [INST_WIDTH-1:0] ld_inst;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    hold_pc_d   = hold_pc_q;
    hold_inst_d = hold_inst_q;
    kill_d      = kill_q;
    ld          = 1'b0;
    ld_pc       = req_pc_q;
    ld_inst     = imem_rsp_data;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (pc_sel) pc_d = pc_imm;
      end
      S_REQ: begin
        if (pc_sel) pc_d = pc_imm;
        if (imem_req_ready) begin
          req_pc_d = pc_q;
          state_d  = S_WAIT;
          // accepted address is stale if redirected in the same cycle
          if (pc_sel) kill_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (kill_q || pc_sel) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
            if (pc_sel) pc_d = pc_imm;
          end else if (!stall) begin
            ld      = 1'b1;
            pc_d    = req_pc_q + PC_WIDTH'(4);
            state_d = S_REQ;
          end else begin
            hold_pc_d   = req_pc_q;
            hold_inst_d = imem_rsp_data;
            pc_d        = req_pc_q + PC_WIDTH'(4);
            state_d     = S_HOLD;
          end
        end else if (pc_sel) begin
          pc_d   = pc_imm;
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (pc_sel) begin
          pc_d    = pc_imm;
          state_d = S_REQ;
        end else if (!stall) begin
          ld      = 1'b1;
          ld_pc   = hold_pc_q;
          ld_inst = hold_inst_q;
          state_d = S_REQ;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      hold_pc_q   <= '0;
      hold_inst_q <= NOP_INST;
      kill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      hold_pc_q   <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
      kill_q      <= kill_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_addr      = pc_q;

  if_id_reg #(
    .PC_WIDTH  (PC_WIDTH),
    .INST_WIDTH(INST_WIDTH),
    .NOP_INST  (NOP_INST)
  ) u_if_id (
    .clk    (clk),
    .reset  (reset),
    .flush_i(IF_flush),
    .stall_i(stall),
    .load_i (ld),
    .pc_i   (ld_pc),
    .inst_i (ld_inst),
    .pc_o   (IF_ID_pc),
    .inst_o (IF_ID_inst),
    .valid_o(IF_ID_valid)
  );

  assign IF_ID_rs1 = IF_ID_inst[19:15];
  assign IF_ID_rs2 = IF_ID_inst[24:20];

endmodule

// File: tb/tb_stage_if.sv
// Directed cycle-table bench for stage_if, plus a mid-fetch reset sequence.
module tb_stage_if;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, pc_sel, IF_flush;
  logic [31:0] pc_imm;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] IF_ID_pc, IF_ID_inst;
  logic [4:0]  IF_ID_rs1, IF_ID_rs2;
  logic        IF_ID_valid;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  stage_if dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .pc_sel        (pc_sel),
    .pc_imm        (pc_imm),
    .IF_flush      (IF_flush),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .IF_ID_pc      (IF_ID_pc),
    .IF_ID_inst    (IF_ID_inst),
    .IF_ID_rs1     (IF_ID_rs1),
    .IF_ID_rs2     (IF_ID_rs2),
    .IF_ID_valid   (IF_ID_valid)
  );

  typedef struct {
    logic        stall, sel, flush, rdy, rv;
    logic [31:0] imm, rd;
    logic        e_rv;
    logic [31:0] e_addr, e_pc, e_inst;
    logic        e_v;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic sl, logic [31:0] im,
                              logic fl, logic rdy, logic rv,
                              logic [31:0] rd, logic erv,
                              logic [31:0] ea, logic [31:0] ep,
                              logic [31:0] ei, logic ev);
    vec_t v;
    v.stall = st; v.sel = sl; v.imm = im; v.flush = fl;
    v.rdy = rdy; v.rv = rv; v.rd = rd;
    v.e_rv = erv; v.e_addr = ea; v.e_pc = ep;
    v.e_inst = ei; v.e_v = ev;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic erv, logic [31:0] ea,
                         logic [31:0] ep, logic [31:0] ei, logic ev);
    logic [31:0] e;
    e = ei;
    chk({tag, ".req_valid"}, 32'(imem_req_valid), 32'(erv));
    chk({tag, ".addr"}, imem_addr, ea);
    chk({tag, ".pc"}, IF_ID_pc, ep);
    chk({tag, ".inst"}, IF_ID_inst, ei);
    chk({tag, ".rs1"}, 32'(IF_ID_rs1), 32'(e[19:15]));
    chk({tag, ".rs2"}, 32'(IF_ID_rs2), 32'(e[24:20]));
    chk({tag, ".valid"}, 32'(IF_ID_valid), 32'(ev));
  endtask

  task automatic idle_in();
    stall = 0; pc_sel = 0; pc_imm = 0; IF_flush = 0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
  endtask

  initial begin
    // stall sel imm flush rdy rv rd | rv addr pc inst valid
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,32'h0,0,NOP,0));
    vecs.push_back(mk(0,0,0,0,1,0,0, 1,32'h0,0,NOP,0));
    vecs.push_back(mk(0,0,0,0,0,1,32'h00500093, 0,32'h0,0,NOP,0));
    vecs.push_back(mk(0,0,0,0,1,0,0, 1,32'h4,0,32'h00500093,1));
    vecs.push_back(mk(0,0,0,0,0,1,32'h00208133, 0,32'h4,0,NOP,0));
    vecs.push_back(mk(0,0,0,0,1,0,0, 1,32'h8,32'h4,32'h00208133,1));
    vecs.push_back(mk(1,0,0,0,0,1,32'h0031a233, 0,32'h8,0,NOP,0));
    vecs.push_back(mk(1,0,0,0,0,0,0, 0,32'hC,0,NOP,0));
    vecs.push_back(mk(1,0,0,0,0,0,0, 0,32'hC,0,NOP,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,32'hC,0,NOP,0));
    vecs.push_back(mk(0,0,0,0,1,0,0, 1,32'hC,32'h8,32'h0031a233,1));
    vecs.push_back(mk(0,0,0,0,0,1,32'h40c58533, 0,32'hC,0,NOP,0));
    vecs.push_back(mk(0,0,0,0,1,0,0, 1,32'h10,32'hC,32'h40c58533,1));
    vecs.push_back(mk(0,1,32'h100,0,0,0,0, 0,32'h10,0,NOP,0));
    vecs.push_back(mk(0,0,0,0,0,1,32'hdeadbeef, 0,32'h100,0,NOP,0));
    vecs.push_back(mk(0,0,0,0,1,0,0, 1,32'h100,0,NOP,0));
    vecs.push_back(mk(0,0,0,0,0,1,32'h00a00093, 0,32'h100,0,NOP,0));
    vecs.push_back(mk(1,0,0,1,0,0,0, 1,32'h104,32'h100,32'h00a00093,1));
    vecs.push_back(mk(0,0,0,0,0,0,0, 1,32'h104,0,NOP,0));
    vecs.push_back(mk(0,1,32'h200,0,0,0,0, 1,32'h104,0,NOP,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 1,32'h200,0,NOP,0));
    vecs.push_back(mk(0,0,0,0,1,0,0, 1,32'h200,0,NOP,0));
    vecs.push_back(mk(0,0,0,0,0,1,32'h002081b3, 0,32'h200,0,NOP,0));
    vecs.push_back(mk(0,1,32'h300,0,1,0,0, 1,32'h204,32'h200,32'h002081b3,1));
    vecs.push_back(mk(0,0,0,0,0,1,32'h0badbad0, 0,32'h300,0,NOP,0));
    vecs.push_back(mk(0,0,0,0,1,0,0, 1,32'h300,0,NOP,0));
    vecs.push_back(mk(0,0,0,0,0,1,32'h00f00093, 0,32'h300,0,NOP,0));
    vecs.push_back(mk(0,1,32'hFFFFFFFC,0,0,0,0, 1,32'h304,32'h300,32'h00f00093,1));
    vecs.push_back(mk(0,0,0,0,1,0,0, 1,32'hFFFFFFFC,0,NOP,0));
    vecs.push_back(mk(0,0,0,0,0,1,32'h00100093, 0,32'hFFFFFFFC,0,NOP,0));
    vecs.push_back(mk(0,0,0,0,0,1,32'hffffffff, 1,32'h0,32'hFFFFFFFC,32'h00100093,1));
    vecs.push_back(mk(0,1,32'h40,0,1,0,0, 1,32'h0,0,NOP,0));

    idle_in();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_all("reset", 0, 32'h0, 0, NOP, 0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      stall          = vecs[i].stall;
      pc_sel         = vecs[i].sel;
      pc_imm         = vecs[i].imm;
      IF_flush       = vecs[i].flush;
      imem_req_ready = vecs[i].rdy;
      imem_rsp_valid = vecs[i].rv;
      imem_rsp_data  = vecs[i].rd;
      #1;
      chk_all($sformatf("cyc%0d", i), vecs[i].e_rv, vecs[i].e_addr,
              vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_v);
      @(negedge clk);
    end

    // Killed fetch outstanding with pc_q=0x40: async reset mid-wait.
    idle_in();
    reset = 1'b1;
    #1;
    chk_all("rst_async", 0, 32'h0, 0, NOP, 0);
    @(negedge clk);
    reset = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h00500093;
    #1;
    chk_all("rst_idle", 0, 32'h0, 0, NOP, 0);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    chk_all("rst_req", 1, 32'h0, 0, NOP, 0);
    @(negedge clk);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h00c00113;
    #1;
    chk_all("rst_wait", 0, 32'h0, 0, NOP, 0);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    #1;
    chk_all("rst_fetch", 1, 32'h4, 0, 32'h00c00113, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
